sha1_schedule: RTL and testbench

//  Message-schedule expander placed directly upstream of sha1_unit.

---
 rtl/sha1_schedule.sv | 128 ++++++++++++
 tb/tb_sha1_schedule.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha1_schedule.sv
// SHA-1 message-schedule expander: loads one 512-bit block, expands W[0..79]
// at WPC words per clock, then holds the schedule on a valid/ready output.
module sha1_schedule #(
    parameter int WPC = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               o_tready_in,
    input  logic               i_tvalid_in,
    input  logic [511:0]       i_block,
    input  logic [31:0]        i_H0,
    input  logic [31:0]        i_H1,
    input  logic [31:0]        i_H2,
    input  logic [31:0]        i_H3,
    input  logic [31:0]        i_H4,
    input  logic               i_tready_out,
    output logic               o_tvalid_out,
    output logic [79:0][31:0]  o_data,
    output logic [31:0]        o_A,
    output logic [31:0]        o_B,
    output logic [31:0]        o_C,
    output logic [31:0]        o_D,
    output logic [31:0]        o_E
);

    generate
        if (!(WPC == 1 || WPC == 2 || WPC == 4)) begin : g_bad_wpc
            $error("sha1_schedule: WPC must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, EXPAND, OUT} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [6:0]              cnt;
    logic                    last_step;
    logic [31:0]             w_first;
    logic [WPC-1:0][31:0]    w_new;

    function automatic logic [31:0] rotl1(input logic [31:0] x);
        return {x[30:0], x[31]};
    endfunction

    assign last_step = (cnt + 7'(WPC)) == 7'd80;

    // Only k=3 (WPC=4) depends on a word made this clock, and that word is always w_first.
    assign w_first = rotl1(o_data[cnt - 7'd3] ^ o_data[cnt - 7'd8] ^
                           o_data[cnt - 7'd14] ^ o_data[cnt - 7'd16]);

    always_comb begin
        w_new = '0;
        for (int k = 0; k < WPC; k++) begin
            if (k == 0) begin
                w_new[k] = w_first;
            end else begin
                w_new[k] = rotl1(((k == 3) ? w_first : o_data[cnt + 7'(k) - 7'd3]) ^
                                 o_data[cnt + 7'(k) - 7'd8] ^
                                 o_data[cnt + 7'(k) - 7'd14] ^
                                 o_data[cnt + 7'(k) - 7'd16]);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        o_tready_in  = 1'b0;
        o_tvalid_out = 1'b0;
        case (state)
            IDLE: begin
                o_tready_in = 1'b1;
                if (i_tvalid_in) state_nxt = EXPAND;
            end
            EXPAND: begin
                if (last_step) state_nxt = OUT;
            end
            OUT: begin
                o_tvalid_out = 1'b1;
                if (i_tready_out) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            o_data <= '0;
            o_A    <= '0;
            o_B    <= '0;
            o_C    <= '0;
            o_D    <= '0;
            o_E    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_tvalid_in) begin
                        for (int t = 0; t < 16; t++) begin
                            o_data[t] <= i_block[511 - 32*t -: 32];
                        end
                        cnt <= 7'd16;
                        o_A <= i_H0;
                        o_B <= i_H1;
                        o_C <= i_H2;
                        o_D <= i_H3;
                        o_E <= i_H4;
                    end
                end
                EXPAND: begin
                    for (int k = 0; k < WPC; k++) begin
                        o_data[cnt + 7'(k)] <= w_new[k];
                    end
                    cnt <= cnt + 7'(WPC);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha1_schedule.sv
// Bench for sha1_schedule: three instances (WPC=1,2,4) checked against a
// plain-loop model of the SHA-1 schedule recurrence.
module tb_sha1_schedule;

    typedef struct packed {
        logic [79:0][31:0] w;
        logic [4:0][31:0]  h;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic              i_tvalid_in, tv2, tv4;
    logic [511:0]      i_block;
    logic [31:0]       i_H0, i_H1, i_H2, i_H3, i_H4;
    logic              i_tready_out;

    logic              o_tready_in, rdy2, rdy4;
    logic              o_tvalid_out, ov2, ov4;
    logic [79:0][31:0] o_data, od2, od4;
    logic [31:0]       o_A, o_B, o_C, o_D, o_E;
    logic [31:0]       a2, b2, c2, d2, e2, a4, b4, c4, d4, e4;

    exp_t q1[$], q2[$], q4[$];
    int   checks = 0;
    int   errors = 0;
    int   xfers1 = 0;

    sha1_schedule #(.WPC(1)) dut (
        .clk(clk), .reset_n(reset_n), .o_tready_in(o_tready_in), .i_tvalid_in(i_tvalid_in),
        .i_block(i_block), .i_H0(i_H0), .i_H1(i_H1), .i_H2(i_H2), .i_H3(i_H3), .i_H4(i_H4),
        .i_tready_out(i_tready_out), .o_tvalid_out(o_tvalid_out), .o_data(o_data),
        .o_A(o_A), .o_B(o_B), .o_C(o_C), .o_D(o_D), .o_E(o_E));

    sha1_schedule #(.WPC(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .o_tready_in(rdy2), .i_tvalid_in(tv2),
        .i_block(i_block), .i_H0(i_H0), .i_H1(i_H1), .i_H2(i_H2), .i_H3(i_H3), .i_H4(i_H4),
        .i_tready_out(i_tready_out), .o_tvalid_out(ov2), .o_data(od2),
        .o_A(a2), .o_B(b2), .o_C(c2), .o_D(d2), .o_E(e2));

    sha1_schedule #(.WPC(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .o_tready_in(rdy4), .i_tvalid_in(tv4),
        .i_block(i_block), .i_H0(i_H0), .i_H1(i_H1), .i_H2(i_H2), .i_H3(i_H3), .i_H4(i_H4),
        .i_tready_out(i_tready_out), .o_tvalid_out(ov4), .o_data(od4),
        .o_A(a4), .o_B(b4), .o_C(c4), .o_D(d4), .o_E(e4));

    // Schedule straight from the definition: copy 16 words, then apply the recurrence.
    function automatic logic [79:0][31:0] model(input logic [511:0] blk);
        logic [31:0]       w [80];
        logic [31:0]       x;
        logic [79:0][31:0] r;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 80; t++) begin
            x    = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
            w[t] = (x << 1) | (x >> 31);
        end
        for (int t = 0; t < 80; t++) r[t] = w[t];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [79:0][31:0] got, input logic [79:0][31:0] exp);
        int bad = -1;
        checks++;
        for (int i = 0; i < 80; i++) if (bad < 0 && got[i] !== exp[i]) bad = i;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s: W[%0d] got %h expected %h", nm, bad, got[bad], exp[bad]);
        end
    endtask

    task automatic cmp(input string nm, input logic rdy, input logic [79:0][31:0] od,
                       input logic [4:0][31:0] oh, input int qsz, input exp_t e);
        if (qsz == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_unexpected_valid: got 1 expected 0", nm);
        end else begin
            chkw({nm, "_data"}, od, e.w);
            for (int i = 0; i < 5; i++) chk($sformatf("%s_h%0d", nm, i), oh[i], e.h[i]);
            chk({nm, "_tready_in"}, {31'd0, rdy}, 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (o_tvalid_out) begin
                cmp("w1", o_tready_in, o_data, {o_E, o_D, o_C, o_B, o_A}, q1.size(),
                    (q1.size() > 0) ? q1[0] : exp_t'(0));
                if (i_tready_out && q1.size() > 0) begin
                    void'(q1.pop_front());
                    xfers1++;
                end
            end
            if (ov2) begin
                cmp("w2", rdy2, od2, {e2, d2, c2, b2, a2}, q2.size(),
                    (q2.size() > 0) ? q2[0] : exp_t'(0));
                if (i_tready_out && q2.size() > 0) void'(q2.pop_front());
            end
            if (ov4) begin
                cmp("w4", rdy4, od4, {e4, d4, c4, b4, a4}, q4.size(),
                    (q4.size() > 0) ? q4[0] : exp_t'(0));
                if (i_tready_out && q4.size() > 0) void'(q4.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
        return b;
    endfunction

    task automatic send1(input logic [511:0] b, input logic [4:0][31:0] h);
        int   n = 0;
        exp_t e;
        while (!o_tready_in && n < 500) begin
            step();
            n++;
        end
        chk("send_ready", {31'd0, o_tready_in}, 32'd1);
        if (o_tready_in) begin
            i_block = b;
            {i_H4, i_H3, i_H2, i_H1, i_H0} = h;
            i_tvalid_in = 1'b1;
            e.w = model(b);
            e.h = h;
            q1.push_back(e);
            step();
            i_tvalid_in = 1'b0;
        end
    endtask

    task automatic run3(input logic [511:0] b, input logic [4:0][31:0] h,
                        output int l1, output int l2, output int l4,
                        output logic [79:0][31:0] snap);
        exp_t e;
        l1 = -1; l2 = -1; l4 = -1; snap = '0;
        chk("run3_ready", {29'd0, o_tready_in, rdy2, rdy4}, 32'd7);
        i_block = b;
        {i_H4, i_H3, i_H2, i_H1, i_H0} = h;
        e.w = model(b);
        e.h = h;
        q1.push_back(e);
        q2.push_back(e);
        q4.push_back(e);
        i_tvalid_in = 1'b1; tv2 = 1'b1; tv4 = 1'b1;
        step();
        i_tvalid_in = 1'b0; tv2 = 1'b0; tv4 = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            step();
            if (o_tvalid_out && l1 < 0) begin
                l1   = c;
                snap = o_data;
            end
            if (ov2 && l2 < 0) l2 = c;
            if (ov4 && l4 < 0) l4 = c;
            if (l1 > 0 && l2 > 0 && l4 > 0) break;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q1.size() + q2.size() + q4.size()) != 0 && n < 3000) begin
            step();
            n++;
        end
        chk("drain_queues", 32'(q1.size() + q2.size() + q4.size()), 32'd0);
    endtask

    localparam logic [4:0][31:0] H_STD = {32'hC3D2E1F0, 32'h10325476, 32'h98BADCFE,
                                          32'hEFCDAB89, 32'h67452301};

    initial begin
        logic [511:0]      abc;
        logic [79:0][31:0] m, snap;
        logic [31:0]       snap_a;
        int                l1, l2, l4, x0, n;

        abc = '0;
        abc[511:480] = 32'h61626380;
        abc[31:0]    = 32'h00000018;

        reset_n = 1'b0; i_tvalid_in = 1'b0; tv2 = 1'b0; tv4 = 1'b0;
        i_block = '0; i_H0 = '0; i_H1 = '0; i_H2 = '0; i_H3 = '0; i_H4 = '0;
        i_tready_out = 1'b1;
        repeat (3) step();

        chk("rst_tvalid_out", {31'd0, o_tvalid_out}, 32'd0);
        chk("rst_tready_in", {29'd0, o_tready_in, rdy2, rdy4}, 32'd7);
        chkw("rst_data", o_data, '0);
        chk("rst_A", o_A, 32'd0);
        chk("rst_E", o_E, 32'd0);
        reset_n = 1'b1;
        step();

        m = model(abc);
        chk("model_W16", m[16], 32'hC2C4C700);
        chk("model_W17", m[17], 32'h00000000);
        chk("model_W18", m[18], 32'h00000030);
        chk("model_W19", m[19], 32'h85898E01);

        // all-zero block: latency per WPC
        run3('0, '0, l1, l2, l4, snap);
        chk("lat_wpc1", 32'(l1), 32'd64);
        chk("lat_wpc2", 32'(l2), 32'd32);
        chk("lat_wpc4", 32'(l4), 32'd16);
        chkw("zero_data", snap, '0);
        drain();

        // "abc" block through all three widths
        run3(abc, H_STD, l1, l2, l4, snap);
        chk("abc_lat_wpc1", 32'(l1), 32'd64);
        chk("abc_lat_wpc4", 32'(l4), 32'd16);
        chk("abc_W0", snap[0], 32'h61626380);
        chk("abc_W16", snap[16], 32'hC2C4C700);
        chk("abc_W17", snap[17], 32'h00000000);
        chk("abc_W18", snap[18], 32'h00000030);
        chk("abc_W19", snap[19], 32'h85898E01);
        drain();

        // backpressure: hold 20 clocks in OUT
        i_tready_out = 1'b0;
        send1(rand_block(), {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
        n = 0;
        while (!o_tvalid_out && n < 200) begin
            step();
            n++;
        end
        chk("hold_reached_out", {31'd0, o_tvalid_out}, 32'd1);
        snap   = o_data;
        snap_a = o_A;
        x0     = xfers1;
        repeat (20) begin
            step();
            chk("hold_tvalid_out", {31'd0, o_tvalid_out}, 32'd1);
            chk("hold_tready_in", {31'd0, o_tready_in}, 32'd0);
        end
        chkw("hold_data_stable", o_data, snap);
        chk("hold_A_stable", o_A, snap_a);
        i_tready_out = 1'b1;
        step();
        chk("release_xfers", 32'(xfers1 - x0), 32'd1);
        chk("release_tvalid_out", {31'd0, o_tvalid_out}, 32'd0);
        chk("release_tready_in", {31'd0, o_tready_in}, 32'd1);
        drain();

        // changing input with valid held high during expansion is ignored
        x0 = xfers1;
        send1(abc, H_STD);
        for (int i = 0; i < 50; i++) begin
            i_tvalid_in = 1'b1;
            i_block     = rand_block();
            i_H0        = $urandom();
            step();
        end
        chk("busy_tready_in", {31'd0, o_tready_in}, 32'd0);
        i_tvalid_in = 1'b0;
        drain();
        chk("busy_xfers", 32'(xfers1 - x0), 32'd1);

        // reset in the middle of expansion (t=40)
        send1(rand_block(), H_STD);
        repeat (24) step();
        reset_n = 1'b0;
        q1.delete();
        #1;
        chk("midrst_tvalid_out", {31'd0, o_tvalid_out}, 32'd0);
        chk("midrst_tready_in", {31'd0, o_tready_in}, 32'd1);
        chkw("midrst_data", o_data, '0);
        chk("midrst_A", o_A, 32'd0);
        step();
        step();
        reset_n = 1'b1;
        step();
        x0 = xfers1;
        send1(abc, H_STD);
        drain();
        chk("postrst_xfers", 32'(xfers1 - x0), 32'd1);

        // ten back-to-back blocks
        x0 = xfers1;
        for (int i = 0; i < 10; i++) begin
            send1(rand_block(), {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
        end
        drain();
        chk("b2b_xfers", 32'(xfers1 - x0), 32'd10);

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
